carry_resolver: RTL

- Final stage of the arithmetic encoder; sits directly downstream of the renormalization stage.
- Accepts one coarse byte per transaction, extracted from the top of the renormalized low register, together with the carry bit out of low.
- Holds the newest non-final byte and a run of pending 0xFF bytes until a carry into them is ruled out, then emits finalized bytes through a valid/ready handshake.
- On flush, drains everything still held and signals completion.

---
 rtl/carry_resolver.sv | 126 ++++++++++++
 1 files changed

// File: rtl/carry_resolver.sv
// carry_resolver: holds the newest byte and a run of pending 0xFF bytes until a carry into them is resolved, then emits finalized bytes
module carry_resolver #(
    parameter int RUN_WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    input  logic       in_carry,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       flush_done,
    output logic       overflow
);
    typedef enum logic [1:0] {IDLE, EMIT_HELD, EMIT_RUN, FLUSH_DONE} state_t;
    localparam logic [RUN_WIDTH-1:0] RUN_MAX = {RUN_WIDTH{1'b1}};
    localparam logic [RUN_WIDTH-1:0] RUN_ONE = RUN_WIDTH'(1);
    state_t state, state_next;
    logic have_held, flushing, tail;
    logic [7:0] held, sched, fill;
    logic [RUN_WIDTH-1:0] run, cnt;
    logic accept, trig, absorb, fl, hs, tail_go;
    assign accept  = state == IDLE && in_valid;
    assign trig    = accept && have_held && (in_carry || in_byte != 8'hFF);
    assign absorb  = accept && have_held && !in_carry && in_byte == 8'hFF;
    assign fl      = state == IDLE && flush;
    assign hs      = out_valid && out_ready;
    assign tail_go = flushing && tail;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: a finished emission continues with the just-loaded byte when flushing, else completes or idles
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       state_next = trig ? EMIT_HELD
                                   : fl ? ((have_held || accept) ? EMIT_HELD : FLUSH_DONE) : IDLE;
            EMIT_HELD:  state_next = !hs ? EMIT_HELD : cnt != '0 ? EMIT_RUN
                                   : tail_go ? EMIT_HELD : flushing ? FLUSH_DONE : IDLE;
            EMIT_RUN:   state_next = (!hs || cnt != RUN_ONE) ? EMIT_RUN
                                   : tail_go ? EMIT_HELD : flushing ? FLUSH_DONE : IDLE;
            FLUSH_DONE: state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready   = state == IDLE;
        out_valid  = state == EMIT_HELD || state == EMIT_RUN;
        out_byte   = state == EMIT_HELD ? sched : state == EMIT_RUN ? fill : 8'h00;
        flush_done = state == FLUSH_DONE;
    end

    // Held byte, pending run and emission schedule
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            have_held <= 1'b0;
            held      <= 8'h00;
            run       <= '0;
            overflow  <= 1'b0;
            sched     <= 8'h00;
            fill      <= 8'h00;
            cnt       <= '0;
            flushing  <= 1'b0;
            tail      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        sched <= in_carry ? held + 8'd1 : held;
                        fill  <= in_carry ? 8'h00 : 8'hFF;
                        cnt   <= run;
                        run   <= '0;
                        held  <= in_byte;
                    end else if (absorb) begin
                        if (run == RUN_MAX) overflow <= 1'b1;
                        else                run <= run + RUN_ONE;
                    end else if (accept) begin
                        held      <= in_byte;
                        have_held <= 1'b1;
                    end
                    if (fl) begin
                        flushing <= 1'b1;
                        tail     <= trig;
                    end
                    if (fl && !trig) begin
                        sched <= (accept && !have_held) ? in_byte : held;
                        fill  <= 8'hFF;
                        cnt   <= (absorb && run != RUN_MAX) ? run + RUN_ONE : run;
                        run   <= '0;
                    end
                end
                EMIT_HELD: begin
                    if (hs && cnt == '0 && tail_go) begin
                        sched <= held;
                        tail  <= 1'b0;
                    end
                end
                EMIT_RUN: begin
                    if (hs) begin
                        cnt <= cnt - RUN_ONE;
                        if (cnt == RUN_ONE && tail_go) begin
                            sched <= held;
                            tail  <= 1'b0;
                        end
                    end
                end
                FLUSH_DONE: begin
                    have_held <= 1'b0;
                    run       <= '0;
                    flushing  <= 1'b0;
                    tail      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
